fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter sequencer and fetch controller for the Fetch stage of the pipelined processor. It owns the PC and drives the instruction-memory address. It loads the reset vector and, optionally, the interrupt vector from memory. It assembles two-word instructions (opcode word plus immediate word) into one IR/immediate pair, and applies hazard-unit stalls and branch flushes. Its outputs feed the Fetch/Decode pipeline register.

## Interface
- `IMM_BIT`, default 15: bit of the instruction word that marks a two-word (immediate) instruction.
- `RST_VEC_ADDR`, default 0: word address of the reset vector (high half); low half is at +1.
- `INT_VEC_ADDR`, default 2: word address of the interrupt vector (high half); low half is at +1.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `stallf` in 1: hazard-unit stall. Holds PC and all outputs.
- `flushf` in 1: taken branch or jump. Redirects the PC.
- `branch_target` in 32: redirect address, sampled when `flushf` is high.
- `int_req` in 1: level interrupt request.
- `instr_in` in 16: instruction-memory read data. Combinational read of word `pc`.
- `pc` out 32: instruction-memory word address.
- `ir_out` out 16: fetched instruction.
- `imm_out` out 16: immediate word. 0 for one-word instructions.
- `ir_valid` out 1: `ir_out`/`imm_out` hold a new instruction this cycle.
- `next_pc` out 32: address of the word following the emitted instruction.
- `int_ack` out 1: one-cycle pulse when an interrupt is taken.
- `epc` out 32: return address saved on interrupt entry.

## Operation
- Word-addressed. The PC increments by 1. All 32-bit PC arithmetic wraps modulo 2^32.
- States: `RST_HI`, `RST_LO`, `FETCH`, `IMM`, `INT_HI`, `INT_LO`.
- `RST_HI`: `pc`=`RST_VEC_ADDR`. Latch `instr_in` as vector[31:16]. Go to `RST_LO`.
- `RST_LO`: `pc`=`RST_VEC_ADDR`+1. Load PC = {vector[31:16], `instr_in`}. Go to `FETCH`.
- `INT_HI` and `INT_LO`: identical to the reset states, but using `INT_VEC_ADDR`.
- `FETCH`, priority order: `flushf` > `stallf` > interrupt > normal.
  - flush: PC ← `branch_target`; `ir_valid` ← 0.
  - stall: hold everything. `ir_valid` keeps its value.
  - interrupt (`int_req` high): `epc` ← `pc`; `int_ack` ← 1; `ir_valid` ← 0; go to `INT_HI`.
  - `instr_in[IMM_BIT]`=1: hold the opcode internally; PC+1; `ir_valid` ← 0; go to `IMM`.
  - otherwise: `ir_out` ← `instr_in`; `imm_out` ← 0; `ir_valid` ← 1; `next_pc` ← PC+1; PC+1.
- `IMM`:
  - flush: drop the held opcode; PC ← `branch_target`; go to `FETCH`.
  - stall: hold.
  - otherwise: `ir_out` ← held opcode; `imm_out` ← `instr_in`; `ir_valid` ← 1; `next_pc` ← PC+1; PC+1; go to `FETCH`.
- Interrupts are taken only in `FETCH`, never in `IMM`, so a two-word instruction is never split.
- In the `RST_*` and `INT_*` states, `flushf`, `stallf` and `int_req` are ignored. Vector loads are atomic.
- `ir_valid` deasserts in every cycle that emits no instruction, except while stalled.

## Timing
- Reset values: state `RST_HI`; `pc`=`RST_VEC_ADDR`; `ir_out`=0; `imm_out`=0; `ir_valid`=0; `next_pc`=0; `int_ack`=0; `epc`=0.
- Asserting `rst` in any state, mid-vector-load included, returns to `RST_HI` on the next edge.
- After `rst` deasserts:
  - edge 1 latches vector high;
  - edge 2 loads PC;
  - edge 3 gives the first `ir_valid` (one-word instruction), or edge 4 if it is a two-word instruction.
- All outputs are registered. Latency is 1 cycle for a one-word instruction and 2 cycles for a two-word instruction.
- A flush takes effect on the next edge: `pc`=`branch_target` the following cycle, and there is exactly one bubble.
- Interrupt entry takes 3 cycles: the ack cycle, then `INT_HI` and `INT_LO`. The first handler instruction is valid one cycle later.
- `int_ack` is high for exactly one cycle.

## Configuration
- `FETCH_INT_EN` defined: interrupt path (`INT_HI`, `INT_LO`, `epc`, `int_ack`) is present, as described above.
- `FETCH_INT_EN` undefined:
  - `int_req` is ignored;
  - `int_ack` and `epc` are tied to 0;
  - the `INT_*` states are absent;
  - `INT_VEC_ADDR` is unused.

## Test plan
- Reset vector: mem[0]=0x0000, mem[1]=0x0010, mem[0x10]=0x1234 (bit 15 = 0) → `pc`=0, then 1, then 0x10; `ir_out`=0x1234, `ir_valid`=1 on edge 3; `next_pc`=0x11.
- Two-word instruction: mem[0x10]=0x8001, mem[0x11]=0xBEEF → one bubble, then `ir_out`=0x8001, `imm_out`=0xBEEF, `next_pc`=0x12.
- Stall in `IMM`: `stallf` high for 3 cycles after the opcode word → `pc` holds at 0x11, `ir_valid` stays 0; the pair is emitted one cycle after `stallf` drops.
- Flush plus stall in the same cycle: `flushf`=1, `stallf`=1, `branch_target`=0x40 → `pc`=0x40 next cycle, `ir_valid`=0 (flush wins).
- Interrupt: mem[2]=0, mem[3]=0x80, `int_req` raised at `pc`=0x20 → `epc`=0x20, one-cycle `int_ack`, `pc` = 2, 3, then 0x80. Raised during `IMM` instead → deferred until the pair is emitted; `epc`=0x12.
- Reset mid-load: `rst` pulsed while in `INT_LO` → state `RST_HI`, `pc`=0, all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//
// Bundles the Fetch-stage signals between the fetch sequencer, the
// instruction memory, the hazard unit and the Fetch/Decode register.
//
// Signals:
//   stallf        hazard-unit stall (to sequencer)
//   flushf        taken branch / jump redirect (to sequencer)
//   branch_target redirect word address, used while flushf is high
//   int_req       level-sensitive interrupt request
//   instr_in      instruction-memory read data for word pc
//   pc            instruction-memory word address
//   ir_out        emitted instruction word
//   imm_out       emitted immediate word (0 for one-word instructions)
//   ir_valid      ir_out/imm_out/next_pc hold a new instruction
//   next_pc       address of the word after the emitted instruction
//   int_ack       one-cycle pulse on interrupt entry
//   epc           return address captured on interrupt entry
//   state         sequencer FSM state, exposed for debug and checkers
//
// Handshake: there is no ready signal. A new instruction is presented in
// every cycle where ir_valid is high and the previous edge was not a
// stall; while stallf is high (and flushf low) every output, ir_valid
// included, holds its previous value, so the consumer may re-read it.
//
// master: the fetch sequencer. slave: the surrounding pipeline / memory.

interface fetch_sequencer_if;
    logic        stallf;
    logic        flushf;
    logic [31:0] branch_target;
    logic        int_req;
    logic [15:0] instr_in;
    logic [31:0] pc;
    logic [15:0] ir_out;
    logic [15:0] imm_out;
    logic        ir_valid;
    logic [31:0] next_pc;
    logic        int_ack;
    logic [31:0] epc;
    logic [2:0]  state;

    modport master (
        input  stallf, flushf, branch_target, int_req, instr_in,
        output pc, ir_out, imm_out, ir_valid, next_pc, int_ack, epc, state
    );

    modport slave (
        output stallf, flushf, branch_target, int_req, instr_in,
        input  pc, ir_out, imm_out, ir_valid, next_pc, int_ack, epc, state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Program-counter sequencer and fetch controller. Owns the PC, loads the
// reset (and optionally interrupt) vector from instruction memory as two
// 16-bit words, merges two-word instructions into an IR/immediate pair,
// and applies hazard stalls and branch flushes. All outputs are registered.
//
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  fetch_sequencer_if.master (see interface file for signal list)
//
// Build option: define FETCH_INT_EN to include the interrupt path
// (INT_HI/INT_LO states, int_ack, epc). Without it int_req is ignored and
// int_ack/epc read as 0.

module fetch_sequencer #(
    parameter int          IMM_BIT      = 15,
    parameter logic [31:0] RST_VEC_ADDR = 32'd0,
    parameter logic [31:0] INT_VEC_ADDR = 32'd2
) (
    input logic              clk,
    input logic              rst,
    fetch_sequencer_if.master bus
);

    localparam logic [2:0] RST_HI = 3'd0;
    localparam logic [2:0] RST_LO = 3'd1;
    localparam logic [2:0] FETCH  = 3'd2;
    localparam logic [2:0] IMM    = 3'd3;
`ifdef FETCH_INT_EN
    localparam logic [2:0] INT_HI = 3'd4;
    localparam logic [2:0] INT_LO = 3'd5;
`endif

    logic [2:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] next_pc_q;
    logic [15:0] ir_q;
    logic [15:0] imm_q;
    logic        valid_q;
    logic [15:0] held_op;   // opcode word waiting for its immediate
    logic [15:0] vec_hi;    // upper half of a vector being loaded
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd1;

`ifdef FETCH_INT_EN
    logic        ack_q;
    logic [31:0] epc_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_HI;
            pc_q      <= RST_VEC_ADDR;
            next_pc_q <= 32'd0;
            ir_q      <= 16'd0;
            imm_q     <= 16'd0;
            valid_q   <= 1'b0;
            held_op   <= 16'd0;
            vec_hi    <= 16'd0;
`ifdef FETCH_INT_EN
            ack_q     <= 1'b0;
            epc_q     <= 32'd0;
`endif
        end else begin
`ifdef FETCH_INT_EN
            // int_ack is a pulse: only the entry cycle below sets it.
            ack_q <= 1'b0;
`endif
            case (state_q)
                // Vector loads ignore stall/flush/interrupt so they stay atomic.
                RST_HI: begin
                    vec_hi  <= bus.instr_in;
                    pc_q    <= RST_VEC_ADDR + 32'd1;
                    valid_q <= 1'b0;
                    state_q <= RST_LO;
                end
                RST_LO: begin
                    pc_q    <= {vec_hi, bus.instr_in};
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
`ifdef FETCH_INT_EN
                INT_HI: begin
                    vec_hi  <= bus.instr_in;
                    pc_q    <= INT_VEC_ADDR + 32'd1;
                    valid_q <= 1'b0;
                    state_q <= INT_LO;
                end
                INT_LO: begin
                    pc_q    <= {vec_hi, bus.instr_in};
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
`endif
                FETCH: begin
                    if (bus.flushf) begin
                        pc_q    <= bus.branch_target;
                        valid_q <= 1'b0;
                    end else if (bus.stallf) begin
                        // hold everything, ir_valid included
                    end
`ifdef FETCH_INT_EN
                    else if (bus.int_req) begin
                        // The un-issued word at pc is where the handler returns.
                        epc_q   <= pc_q;
                        ack_q   <= 1'b1;
                        valid_q <= 1'b0;
                        pc_q    <= INT_VEC_ADDR;
                        state_q <= INT_HI;
                    end
`endif
                    else if (bus.instr_in[IMM_BIT]) begin
                        held_op <= bus.instr_in;
                        pc_q    <= pc_inc;
                        valid_q <= 1'b0;
                        state_q <= IMM;
                    end else begin
                        ir_q      <= bus.instr_in;
                        imm_q     <= 16'd0;
                        valid_q   <= 1'b1;
                        next_pc_q <= pc_inc;
                        pc_q      <= pc_inc;
                    end
                end
                IMM: begin
                    if (bus.flushf) begin
                        pc_q    <= bus.branch_target;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (bus.stallf) begin
                        // hold; the opcode stays parked in held_op
                    end else begin
                        ir_q      <= held_op;
                        imm_q     <= bus.instr_in;
                        valid_q   <= 1'b1;
                        next_pc_q <= pc_inc;
                        pc_q      <= pc_inc;
                        state_q   <= FETCH;
                    end
                end
                default: begin
                    state_q <= RST_HI;
                    pc_q    <= RST_VEC_ADDR;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.ir_out   = ir_q;
    assign bus.imm_out  = imm_q;
    assign bus.ir_valid = valid_q;
    assign bus.next_pc  = next_pc_q;
    assign bus.state    = state_q;

`ifdef FETCH_INT_EN
    assign bus.int_ack = ack_q;
    assign bus.epc     = epc_q;
`else
    assign bus.int_ack = 1'b0;
    assign bus.epc     = 32'd0;
    // Interrupt input and vector address have no function in this build.
    logic                  int_req_unused;
    localparam logic [31:0] INT_VEC_UNUSED = INT_VEC_ADDR;
    assign int_req_unused = bus.int_req;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Bench for fetch_sequencer: a 256-word instruction memory model, a
// per-cycle vector table for PC / ir_valid / emitted-data checks, a
// scoreboard of emitted instructions, and hand-written sequences for
// interrupt entry and reset during a vector load.

module tb_fetch_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:255];
    assign bus.instr_in = mem[bus.pc[7:0]];

    int total = 0;
    int bad   = 0;

    // ---------------- vector table ----------------
    typedef struct {
        logic        stallf;
        logic        flushf;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [15:0] exp_ir;
        logic [15:0] exp_imm;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;
    logic        emit_possible = 1'b0;

    always @(posedge clk)
        emit_possible <= !rst && !(bus.stallf && !bus.flushf);

    always @(negedge clk) begin
        if (bus.ir_valid && emit_possible) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got ir=%h imm=%h next=%h required nothing",
                         bus.ir_out, bus.imm_out, bus.next_pc);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({bus.ir_out, bus.imm_out, bus.next_pc} !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_emit: got %h_%h_%h required %h_%h_%h",
                             bus.ir_out, bus.imm_out, bus.next_pc,
                             sb_exp[63:48], sb_exp[47:32], sb_exp[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   32'(bus.state), 32'd0);
        check({tag, "_pc"},      bus.pc, 32'd0);
        check({tag, "_ir"},      32'(bus.ir_out), 32'd0);
        check({tag, "_imm"},     32'(bus.imm_out), 32'd0);
        check({tag, "_valid"},   32'(bus.ir_valid), 32'd0);
        check({tag, "_next"},    bus.next_pc, 32'd0);
        check({tag, "_int_ack"}, 32'(bus.int_ack), 32'd0);
        check({tag, "_epc"},     bus.epc, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst               = 1'b1;
        bus.stallf        = 1'b0;
        bus.flushf        = 1'b0;
        bus.branch_target = 32'd0;
        bus.int_req       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        mem[8'h00] = 16'h0000; mem[8'h01] = 16'h0010;
        mem[8'h10] = 16'h1234; mem[8'h11] = 16'h8001; mem[8'h12] = 16'hBEEF;
        mem[8'h13] = 16'h0042; mem[8'h14] = 16'h8002; mem[8'h15] = 16'h1111;
        mem[8'h16] = 16'h0007;
        mem[8'h40] = 16'h0A0A; mem[8'h41] = 16'h8003; mem[8'h42] = 16'h2222;
        mem[8'h50] = 16'h0B0B;
        mem[8'hFF] = 16'h0C0C;

        //               stall flush target         pc             v  ir        imm       next
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h1,        1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h10,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h11,       1'b1, 16'h1234, 16'h0,    32'h11});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h12,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h13,       1'b1, 16'h8001, 16'hBEEF, 32'h13});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h14,       1'b1, 16'h0042, 16'h0,    32'h14});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h15,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h15,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h15,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h15,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h16,       1'b1, 16'h8002, 16'h1111, 32'h16});
        vecs.push_back('{1'b1, 1'b0, 32'h0,        32'h16,       1'b1, 16'h8002, 16'h1111, 32'h16});
        vecs.push_back('{1'b1, 1'b1, 32'h40,       32'h40,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h41,       1'b1, 16'h0A0A, 16'h0,    32'h41});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h42,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h50,       32'h50,       1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h51,       1'b1, 16'h0B0B, 16'h0,    32'h51});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'h0,    16'h0,    32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 16'h0C0C, 16'h0,    32'h0});

        // Reset state
        repeat (2) tick();
        check_reset_values("reset");
        rst = 1'b0;

        // Table-driven run from the reset vector
        for (int i = 0; i < vecs.size(); i++) begin
            bus.stallf        = vecs[i].stallf;
            bus.flushf        = vecs[i].flushf;
            bus.branch_target = vecs[i].target;
            if (vecs[i].exp_valid && !(vecs[i].stallf && !vecs[i].flushf))
                exp_q.push_back({vecs[i].exp_ir, vecs[i].exp_imm, vecs[i].exp_next});
            tick();
            check($sformatf("v%0d_pc", i),    bus.pc, vecs[i].exp_pc);
            check($sformatf("v%0d_valid", i), 32'(bus.ir_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_ir", i),   32'(bus.ir_out), 32'(vecs[i].exp_ir));
                check($sformatf("v%0d_imm", i),  32'(bus.imm_out), 32'(vecs[i].exp_imm));
                check($sformatf("v%0d_next", i), bus.next_pc, vecs[i].exp_next);
            end
        end
        bus.stallf = 1'b0;
        bus.flushf = 1'b0;

`ifdef FETCH_INT_EN
        // Interrupt taken in FETCH at pc 0x20
        mem[8'h01] = 16'h0020; mem[8'h02] = 16'h0000; mem[8'h03] = 16'h0080;
        mem[8'h20] = 16'h3333; mem[8'h80] = 16'h0D0D;
        do_reset();
        tick(); tick();
        check("int_start_pc", bus.pc, 32'h20);
        bus.int_req = 1'b1;
        tick();
        check("int_ack_hi", 32'(bus.int_ack), 32'd1);
        check("int_epc", bus.epc, 32'h20);
        check("int_pc_hi", bus.pc, 32'h2);
        check("int_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        check("int_ack_pulse", 32'(bus.int_ack), 32'd0);
        check("int_pc_lo", bus.pc, 32'h3);
        tick();
        check("int_pc_vec", bus.pc, 32'h80);
        bus.int_req = 1'b0;
        exp_q.push_back({16'h0D0D, 16'h0000, 32'h81});
        tick();
        check("int_first_valid", 32'(bus.ir_valid), 32'd1);
        check("int_first_pc", bus.pc, 32'h81);

        // Interrupt raised while in IMM is deferred past the pair
        mem[8'h01] = 16'h0010; mem[8'h10] = 16'h8001; mem[8'h11] = 16'hBEEF;
        do_reset();
        tick(); tick(); tick();
        check("imm_int_pc", bus.pc, 32'h11);
        bus.int_req = 1'b1;
        exp_q.push_back({16'h8001, 16'hBEEF, 32'h12});
        tick();
        check("imm_int_pair_valid", 32'(bus.ir_valid), 32'd1);
        check("imm_int_no_ack", 32'(bus.int_ack), 32'd0);
        tick();
        check("imm_int_ack", 32'(bus.int_ack), 32'd1);
        check("imm_int_epc", bus.epc, 32'h12);
        tick();
        check("imm_int_pc_lo", bus.pc, 32'h3);
        // Reset while in INT_LO
        rst = 1'b1;
        tick();
        check_reset_values("rst_mid_int");
        rst = 1'b0;
        bus.int_req = 1'b0;
`else
        // Interrupt path absent: int_req has no effect
        mem[8'h01] = 16'h0020; mem[8'h20] = 16'h3333;
        do_reset();
        tick(); tick();
        check("noint_pc", bus.pc, 32'h20);
        bus.int_req = 1'b1;
        exp_q.push_back({16'h3333, 16'h0000, 32'h21});
        tick();
        check("noint_pc_next", bus.pc, 32'h21);
        check("noint_valid", 32'(bus.ir_valid), 32'd1);
        check("noint_ack", 32'(bus.int_ack), 32'd0);
        check("noint_epc", bus.epc, 32'd0);
        bus.int_req = 1'b0;
        // Reset while in RST_LO
        do_reset();
        tick();
        check("rst_lo_pc", bus.pc, 32'h1);
        rst = 1'b1;
        tick();
        check_reset_values("rst_mid_load");
        rst = 1'b0;
`endif

        tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
